// File: rtl/riscv_id_pkg.sv
// Shared decode constants for the RV32I/RV32E decode stage: opcodes, ALU
// control encodings, immediate formats and the immediate generator.
package riscv_id_pkg;

    // Base opcodes handled by this decoder; anything else is flagged illegal.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU control is {instr[30], funct3}; named values for the execute stage.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // Immediate layouts; IMM_R means "no immediate" and yields zero.
    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_fmt_e;

    // Builds the immediate sign-extended to 64 bits; callers truncate to XLEN.
    function automatic logic [63:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [63:0] imm;
        case (fmt)
            IMM_I:   imm = {{52{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            IMM_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 64'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: NREGS x XLEN, two asynchronous read ports,
// one synchronous write port, synchronous clear. x0 has no storage and reads
// zero; indices at or above NREGS match no entry, so writes to them are lost
// and reads of them return zero.
module id_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs_r [1:NREGS-1];

    // Clear every entry on reset, otherwise write the addressed entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (we) begin
            for (int i = 1; i < NREGS; i++) begin
                if (wa == 5'(i)) begin
                    regs_r[i] <= wd;
                end
            end
        end
    end

    // Read port 1: decoded select, zero for x0 and out-of-range indices.
    always_comb begin
        rd1 = {XLEN{1'b0}};
        for (int i = 1; i < NREGS; i++) begin
            rd1 = (ra1 == 5'(i)) ? regs_r[i] : rd1;
        end
    end

    // Read port 2: same structure as port 1.
    always_comb begin
        rd2 = {XLEN{1'b0}};
        for (int i = 1; i < NREGS; i++) begin
            rd2 = (ra2 == 5'(i)) ? regs_r[i] : rd2;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: decodes the fetched instruction, reads operands with a
// writeback bypass, and holds the result in a single output slot with
// valid/ready handshakes, load-use bubbles, flush and in-slot operand refresh.
module id_stage_pipe
    import riscv_id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_load_valid,
    input  logic [4:0]      ex_load_rd,
    input  logic            ex_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [XLEN-1:0] id_rs1_data,
    output logic [XLEN-1:0] id_rs2_data,
    output logic [XLEN-1:0] id_imm,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_func3,
    output logic [3:0]      id_alu_ctrl,
    output logic            id_reg_write,
    output logic            id_illegal
);

    // True when a register index exists in this configuration.
    function automatic logic idx_ok(input logic [4:0] idx);
        return ({1'b0, idx} < 6'(NREGS));
    endfunction

    // Decoder outputs for the incoming instruction.
    logic [6:0]      opcode_s;
    logic [2:0]      func3_s;
    logic [4:0]      rs1_idx_s;
    logic [4:0]      rs2_idx_s;
    logic [4:0]      rd_idx_s;
    imm_fmt_e        fmt_s;
    logic            uses_rs1_s;
    logic            uses_rs2_s;
    logic            writes_rd_s;
    logic            opc_ok_s;
    logic [3:0]      alu_ctrl_s;
    logic            illegal_s;
    logic            reg_write_s;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] rf_rd1_s;
    logic [XLEN-1:0] rf_rd2_s;
    logic [XLEN-1:0] rs1_data_s;
    logic [XLEN-1:0] rs2_data_s;

    // Handshake and hazard controls.
    logic hazard_s;
    logic accept_s;
    logic handoff_s;
    logic if_ready_s;
    logic id_valid_s;

    // Output slot.
    logic            slot_full_r;
    logic [XLEN-1:0] pc_r;
    logic [4:0]      rs1_r;
    logic [4:0]      rs2_r;
    logic [4:0]      rd_r;
    logic [XLEN-1:0] rs1_data_r;
    logic [XLEN-1:0] rs2_data_r;
    logic [XLEN-1:0] imm_r;
    logic [6:0]      opcode_r;
    logic [2:0]      func3_r;
    logic [3:0]      alu_ctrl_r;
    logic            reg_write_r;
    logic            illegal_r;
    logic            uses_rs1_r;
    logic            uses_rs2_r;

    id_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1_idx_s),
        .rd1 (rf_rd1_s),
        .ra2 (rs2_idx_s),
        .rd2 (rf_rd2_s),
        .we  (wb_we),
        .wa  (wb_rd),
        .wd  (wb_data)
    );

    // Field extraction and opcode classification of the fetched instruction.
    always_comb begin
        opcode_s    = if_instr[6:0];
        func3_s     = if_instr[14:12];
        rs1_idx_s   = if_instr[19:15];
        rs2_idx_s   = if_instr[24:20];
        rd_idx_s    = if_instr[11:7];
        fmt_s       = IMM_R;
        uses_rs1_s  = 1'b1;
        uses_rs2_s  = 1'b0;
        writes_rd_s = 1'b0;
        opc_ok_s    = 1'b0;
        alu_ctrl_s  = ALU_ADD;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC: begin
                fmt_s       = IMM_U;
                uses_rs1_s  = 1'b0;
                writes_rd_s = 1'b1;
                opc_ok_s    = 1'b1;
            end
            OPC_JAL: begin
                fmt_s       = IMM_J;
                uses_rs1_s  = 1'b0;
                writes_rd_s = 1'b1;
                opc_ok_s    = 1'b1;
            end
            OPC_JALR, OPC_LOAD: begin
                fmt_s       = IMM_I;
                writes_rd_s = 1'b1;
                opc_ok_s    = 1'b1;
            end
            OPC_BRANCH: begin
                fmt_s      = IMM_B;
                uses_rs2_s = 1'b1;
                opc_ok_s   = 1'b1;
            end
            OPC_STORE: begin
                fmt_s      = IMM_S;
                uses_rs2_s = 1'b1;
                opc_ok_s   = 1'b1;
            end
            OPC_OP_IMM: begin
                fmt_s       = IMM_I;
                writes_rd_s = 1'b1;
                opc_ok_s    = 1'b1;
                // Only the shift-right group uses instr[30] (SRAI vs SRLI).
                alu_ctrl_s  = {(func3_s == 3'b101) ? if_instr[30] : 1'b0, func3_s};
            end
            OPC_OP: begin
                uses_rs2_s  = 1'b1;
                writes_rd_s = 1'b1;
                opc_ok_s    = 1'b1;
                alu_ctrl_s  = {if_instr[30], func3_s};
            end
            default: begin
                opc_ok_s = 1'b0;
            end
        endcase
    end

    // Legality, write enable, immediate and bypassed operands.
    always_comb begin
        illegal_s = (if_instr[1:0] != 2'b11) | !opc_ok_s
                  | (uses_rs1_s  & !idx_ok(rs1_idx_s))
                  | (uses_rs2_s  & !idx_ok(rs2_idx_s))
                  | (writes_rd_s & !idx_ok(rd_idx_s));
        // Illegal instructions still travel down the pipe but never write back.
        reg_write_s = writes_rd_s & (rd_idx_s != 5'd0) & !illegal_s;
        imm_s       = XLEN'(imm_gen(if_instr, fmt_s));
        rs1_data_s  = (wb_we && (wb_rd == rs1_idx_s) && (rs1_idx_s != 5'd0)) ? wb_data : rf_rd1_s;
        rs2_data_s  = (wb_we && (wb_rd == rs2_idx_s) && (rs2_idx_s != 5'd0)) ? wb_data : rf_rd2_s;
    end

    // Load-use detection against the slotted instruction and handshake terms.
    always_comb begin
        hazard_s = slot_full_r & ex_load_valid & (ex_load_rd != 5'd0)
                 & ((uses_rs1_r & (rs1_r == ex_load_rd)) | (uses_rs2_r & (rs2_r == ex_load_rd)));
        id_valid_s = slot_full_r & !hazard_s;
        if_ready_s = !rst & !hazard_s & (!slot_full_r | ex_ready);
        accept_s   = if_valid & if_ready_s & !flush;
        // A flush drops the slot, so it never counts as a handoff.
        handoff_s  = id_valid_s & ex_ready & !flush;
    end

    // Output slot: reload on accept, empty on handoff or flush, else hold and
    // pick up writeback results for the held operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full_r <= 1'b0;
            pc_r        <= {XLEN{1'b0}};
            rs1_r       <= 5'd0;
            rs2_r       <= 5'd0;
            rd_r        <= 5'd0;
            rs1_data_r  <= {XLEN{1'b0}};
            rs2_data_r  <= {XLEN{1'b0}};
            imm_r       <= {XLEN{1'b0}};
            opcode_r    <= 7'd0;
            func3_r     <= 3'd0;
            alu_ctrl_r  <= 4'd0;
            reg_write_r <= 1'b0;
            illegal_r   <= 1'b0;
            uses_rs1_r  <= 1'b0;
            uses_rs2_r  <= 1'b0;
        end else begin
            if (flush) begin
                slot_full_r <= 1'b0;
            end else if (accept_s) begin
                slot_full_r <= 1'b1;
            end else if (handoff_s) begin
                slot_full_r <= 1'b0;
            end else begin
                slot_full_r <= slot_full_r;
            end

            if (accept_s) begin
                pc_r        <= if_pc;
                rs1_r       <= rs1_idx_s;
                rs2_r       <= rs2_idx_s;
                rd_r        <= rd_idx_s;
                rs1_data_r  <= rs1_data_s;
                rs2_data_r  <= rs2_data_s;
                imm_r       <= imm_s;
                opcode_r    <= opcode_s;
                func3_r     <= func3_s;
                alu_ctrl_r  <= alu_ctrl_s;
                reg_write_r <= reg_write_s;
                illegal_r   <= illegal_s;
                uses_rs1_r  <= uses_rs1_s;
                uses_rs2_r  <= uses_rs2_s;
            end else begin
                if (wb_we && (wb_rd == rs1_r) && (rs1_r != 5'd0)) begin
                    rs1_data_r <= wb_data;
                end
                if (wb_we && (wb_rd == rs2_r) && (rs2_r != 5'd0)) begin
                    rs2_data_r <= wb_data;
                end
            end
        end
    end

    assign if_ready     = if_ready_s;
    assign id_valid     = id_valid_s;
    assign id_pc        = pc_r;
    assign id_rs1       = rs1_r;
    assign id_rs2       = rs2_r;
    assign id_rd        = rd_r;
    assign id_rs1_data  = rs1_data_r;
    assign id_rs2_data  = rs2_data_r;
    assign id_imm       = imm_r;
    assign id_opcode    = opcode_r;
    assign id_func3     = func3_r;
    assign id_alu_ctrl  = alu_ctrl_r;
    assign id_reg_write = reg_write_r;
    assign id_illegal   = illegal_r;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: one RV32I instance (NREGS=32) and one
// RV32E instance (NREGS=16) share the stimulus.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_load_valid;
    logic [4:0]  ex_load_rd;
    logic        ex_ready;

    logic        a_if_ready, a_valid, a_rw, a_ill;
    logic [31:0] a_pc, a_d1, a_d2, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [6:0]  a_opc;
    logic [2:0]  a_f3;
    logic [3:0]  a_alu;

    logic        b_if_ready, b_valid, b_rw, b_ill;
    logic [31:0] b_pc, b_d1, b_d2, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [6:0]  b_opc;
    logic [2:0]  b_f3;
    logic [3:0]  b_alu;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NREGS(32)) dut32 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(a_if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .ex_ready(ex_ready),
        .id_valid(a_valid), .id_pc(a_pc), .id_rs1(a_rs1), .id_rs2(a_rs2), .id_rd(a_rd),
        .id_rs1_data(a_d1), .id_rs2_data(a_d2), .id_imm(a_imm), .id_opcode(a_opc),
        .id_func3(a_f3), .id_alu_ctrl(a_alu), .id_reg_write(a_rw), .id_illegal(a_ill)
    );

    id_stage_pipe #(.XLEN(32), .NREGS(16)) dut16 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(b_if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .ex_ready(ex_ready),
        .id_valid(b_valid), .id_pc(b_pc), .id_rs1(b_rs1), .id_rs2(b_rs2), .id_rd(b_rd),
        .id_rs1_data(b_d1), .id_rs2_data(b_d2), .id_imm(b_imm), .id_opcode(b_opc),
        .id_func3(b_f3), .id_alu_ctrl(b_alu), .id_reg_write(b_rw), .id_illegal(b_ill)
    );

    typedef struct {
        logic [31:0] instr;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        rw;
        logic        ill;
        logic [31:0] d1;
        logic [31:0] d2;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // instr, wb_we, wb_rd, wb_data, rd, rs1, rs2, imm, alu, rw, ill, d1, d2
        vecs[0]  = '{32'h007302B3, 1'b0, 5'd0, 32'h0,    5'd5,  5'd6,  5'd7,  32'h0,        4'b0000, 1'b1, 1'b0, 32'h0,  32'h0};
        vecs[1]  = '{32'h407302B3, 1'b0, 5'd0, 32'h0,    5'd5,  5'd6,  5'd7,  32'h0,        4'b1000, 1'b1, 1'b0, 32'h0,  32'h0};
        vecs[2]  = '{32'hFE208EE3, 1'b0, 5'd0, 32'h0,    5'd29, 5'd1,  5'd2,  32'hFFFFFFFC, 4'b0000, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[3]  = '{32'h007302B3, 1'b1, 5'd6, 32'h55,   5'd5,  5'd6,  5'd7,  32'h0,        4'b0000, 1'b1, 1'b0, 32'h55, 32'h0};
        vecs[4]  = '{32'hFFF30513, 1'b0, 5'd0, 32'h0,    5'd10, 5'd6,  5'd31, 32'hFFFFFFFF, 4'b0000, 1'b1, 1'b0, 32'h55, 32'h0};
        vecs[5]  = '{32'h40435193, 1'b0, 5'd0, 32'h0,    5'd3,  5'd6,  5'd4,  32'h00000404, 4'b1101, 1'b1, 1'b0, 32'h55, 32'h0};
        vecs[6]  = '{32'h12345437, 1'b0, 5'd0, 32'h0,    5'd8,  5'd8,  5'd3,  32'h12345000, 4'b0000, 1'b1, 1'b0, 32'h0,  32'h0};
        vecs[7]  = '{32'h00612423, 1'b0, 5'd0, 32'h0,    5'd8,  5'd2,  5'd6,  32'h00000008, 4'b0000, 1'b0, 1'b0, 32'h0,  32'h55};
        vecs[8]  = '{32'hFF9FF0EF, 1'b0, 5'd0, 32'h0,    5'd1,  5'd31, 5'd25, 32'hFFFFFFF8, 4'b0000, 1'b1, 1'b0, 32'h0,  32'h0};
        vecs[9]  = '{32'h007344B3, 1'b1, 5'd7, 32'h77,   5'd9,  5'd6,  5'd7,  32'h0,        4'b0100, 1'b1, 1'b0, 32'h55, 32'h77};
        vecs[10] = '{32'h00000073, 1'b0, 5'd0, 32'h0,    5'd0,  5'd0,  5'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 32'h0,  32'h0};
        vecs[11] = '{32'h00000000, 1'b1, 5'd0, 32'hDEAD, 5'd0,  5'd0,  5'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 32'h0,  32'h0};

        rst = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0; flush = 1'b0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        ex_load_valid = 1'b0; ex_load_rd = 5'd0; ex_ready = 1'b1;

        // Reset: three cycles, instruction offered in the last one must be ignored.
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                if_valid = 1'b1; if_instr = 32'h007302B3; if_pc = 32'h10000000;
            end
            tick();
            chk("rst_if_ready", a_if_ready, 1'b0);
            chk("rst_id_valid", a_valid, 1'b0);
        end
        chk("rst_id_pc", a_pc, 32'h0);
        chk("rst_id_rd", a_rd, 5'd0);
        chk("rst_id_rw", a_rw, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_if_ready", a_if_ready, 1'b1);
        chk("post_rst_if_ready16", b_if_ready, 1'b1);

        // Table: one instruction per cycle with ex_ready held high.
        for (int i = 0; i < 12; i++) begin
            if_valid = 1'b1;
            if_instr = vecs[i].instr;
            if_pc    = 32'h10000000 + 32'(4 * i);
            wb_we    = vecs[i].wb_we;
            wb_rd    = vecs[i].wb_rd;
            wb_data  = vecs[i].wb_data;
            tick();
            chk($sformatf("v%0d_valid", i), a_valid, 1'b1);
            chk($sformatf("v%0d_pc", i), a_pc, 32'h10000000 + 32'(4 * i));
            chk($sformatf("v%0d_rd", i), a_rd, vecs[i].rd);
            chk($sformatf("v%0d_rs1", i), a_rs1, vecs[i].rs1);
            chk($sformatf("v%0d_rs2", i), a_rs2, vecs[i].rs2);
            chk($sformatf("v%0d_imm", i), a_imm, vecs[i].imm);
            chk($sformatf("v%0d_alu", i), a_alu, vecs[i].alu);
            chk($sformatf("v%0d_rw", i), a_rw, vecs[i].rw);
            chk($sformatf("v%0d_ill", i), a_ill, vecs[i].ill);
            chk($sformatf("v%0d_d1", i), a_d1, vecs[i].d1);
            chk($sformatf("v%0d_d2", i), a_d2, vecs[i].d2);
            chk($sformatf("v%0d_opc", i), a_opc, {25'd0, vecs[i].instr[6:0]});
        end
        if_valid = 1'b0; wb_we = 1'b0;
        tick();
        chk("drain_valid", a_valid, 1'b0);

        // Refresh: slot held by ex_ready=0 picks up a writeback to rs2.
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h007302B3; if_pc = 32'h20000000;
        tick();
        chk("hold_valid", a_valid, 1'b1);
        chk("hold_if_ready", a_if_ready, 1'b0);
        if_instr = 32'h407302B3; wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hAA;
        tick();
        wb_we = 1'b0;
        chk("refresh_d2", a_d2, 32'hAA);
        chk("refresh_d1", a_d1, 32'h55);
        chk("refresh_alu_stable", a_alu, 4'b0000);
        chk("refresh_pc_stable", a_pc, 32'h20000000);
        chk("refresh_valid", a_valid, 1'b1);
        ex_ready = 1'b1; if_valid = 1'b0;
        tick();
        chk("refresh_drain", a_valid, 1'b0);

        // Load-use bubble on rs1 with refresh from the load's writeback.
        if_valid = 1'b1; if_instr = 32'h007302B3; if_pc = 32'h30000000;
        tick();
        ex_load_valid = 1'b1; ex_load_rd = 5'd6; if_instr = 32'h407302B3; if_pc = 32'h30000004;
        wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
        #1;
        chk("lu_valid", a_valid, 1'b0);
        chk("lu_if_ready", a_if_ready, 1'b0);
        tick();
        ex_load_valid = 1'b0; wb_we = 1'b0;
        #1;
        chk("lu_rec_valid", a_valid, 1'b1);
        chk("lu_rec_if_ready", a_if_ready, 1'b1);
        chk("lu_rec_alu", a_alu, 4'b0000);
        chk("lu_rec_d1", a_d1, 32'h66);
        tick();
        chk("lu_next_alu", a_alu, 4'b1000);
        chk("lu_next_pc", a_pc, 32'h30000004);
        ex_load_valid = 1'b1; ex_load_rd = 5'd7;
        #1;
        chk("lu_rs2_valid", a_valid, 1'b0);
        ex_load_rd = 5'd0;
        #1;
        chk("lu_x0_valid", a_valid, 1'b1);
        ex_load_valid = 1'b0;

        // Flush with an incoming instruction: slot and incoming both dropped,
        // but the register write in the same cycle lands.
        flush = 1'b1; if_instr = 32'h007302B3; wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
        tick();
        flush = 1'b0; if_valid = 1'b0; wb_we = 1'b0;
        #1;
        chk("flush_valid", a_valid, 1'b0);
        tick();
        chk("flush_still_empty", a_valid, 1'b0);
        if_valid = 1'b1; if_instr = 32'h000482B3; if_pc = 32'h40000000;
        tick();
        chk("flush_wb_valid", a_valid, 1'b1);
        chk("flush_wb_d1", a_d1, 32'h99);

        // RV32E: x20 is out of range; the write to x20 must not alias onto x4.
        if_instr = 32'h00100A13; wb_we = 1'b1; wb_rd = 5'd20; wb_data = 32'h1234;
        tick();
        wb_we = 1'b0;
        chk("e_valid", b_valid, 1'b1);
        chk("e_illegal", b_ill, 1'b1);
        chk("e_rw", b_rw, 1'b0);
        chk("i_illegal", a_ill, 1'b0);
        chk("i_rw", a_rw, 1'b1);
        chk("i_imm", a_imm, 32'h1);
        if_instr = 32'h000202B3;
        tick();
        chk("e_x4_d1", b_d1, 32'h0);
        chk("e_x4_illegal", b_ill, 1'b0);
        chk("e_x4_rw", b_rw, 1'b1);
        if_valid = 1'b0;
        tick();
        chk("end_drain", a_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode stage for the pipelined RISC-V core, sitting between the fetch stage and the execute stage. It decodes RV32I/RV32E instructions and reads the register file (one-cycle write-through bypass from writeback). A registered output slot carries the decoded instruction with a valid/ready handshake on both sides. It adds stall, flush, load-use bubble insertion and in-slot operand refresh from writeback.

## Interface
- XLEN, 32: datapath and PC width (32 or 64); immediates sign-extended to XLEN.
- NREGS, 32: architectural registers (32 = RV32I, 16 = RV32E).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  decode accepts this cycle.
- if_instr  in  32  instruction word.
- if_pc  in  XLEN  PC of if_instr.
- flush  in  1  kill slot contents and any incoming instruction.
- wb_we, wb_rd, wb_data  in  1/5/XLEN  writeback port.
- ex_load_valid, ex_load_rd  in  1/5  a load is in EX and advances this cycle, with its destination register.
- ex_ready  in  1  EX accepts the slot contents.
- id_valid  out  1  slot holds a valid, hazard-free instruction.
- id_pc  out  XLEN  PC of the slotted instruction.
- id_rs1, id_rs2, id_rd  out  5 each  register indices.
- id_rs1_data, id_rs2_data  out  XLEN each  register operands.
- id_imm  out  XLEN  sign-extended immediate.
- id_opcode  out  7  opcode field.
- id_func3  out  3  funct3 field.
- id_alu_ctrl  out  4  ALU operation.
- id_reg_write  out  1  instruction writes a register (rd != 0).
- id_illegal  out  1  instruction is unsupported or out of range.

## Operation
- Register file: NREGS x XLEN; x0 reads 0 and ignores writes; writes to an index ≥ NREGS are ignored; all registers clear on rst.
- Read with bypass: if wb_we, wb_rd == rs and rs != 0, the operand is wb_data; otherwise it is the register file value.
- Accept: an instruction is accepted when if_valid & if_ready & !flush. Decoded fields and operands are written into the slot, and slot_full is set.
- Handoff: when id_valid & ex_ready, the slot empties unless a new instruction is accepted in the same cycle. In that case the slot reloads and stays full.
- if_ready = !rst & !hazard & (!slot_full | ex_ready).
- Load-use hazard: slot_full & ex_load_valid & ex_load_rd != 0, and either (uses_rs1 & id_rs1 == ex_load_rd) or (uses_rs2 & id_rs2 == ex_load_rd).
  - While the hazard holds, id_valid = 0 and the slot is held (bubble).
- id_valid = slot_full & !hazard.
- Operand refresh: while the slot is held, any wb_we to id_rs1 or id_rs2 (index nonzero) overwrites the corresponding id_rsX_data on the next edge.
- Flush has highest priority: slot_full clears and if_* is ignored that cycle. Register file writes and refresh still occur.
- uses_rs1: all opcodes except LUI, AUIPC and JAL. uses_rs2: BRANCH, STORE and OP.
- Immediate formats:
  - I: LOAD, OP-IMM, JALR.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - R-type: 0.
- id_alu_ctrl:
  - OP: {instr[30], funct3}.
  - OP-IMM: {funct3 == 101 ? instr[30] : 0, funct3}.
  - All other opcodes: 4'b0000 (add).
- id_illegal is set for any of:
  - instr[1:0] != 11;
  - an unsupported opcode;
  - any used register index ≥ NREGS.
  
  An illegal instruction still flows through with id_reg_write = 0.

## Timing
- Latency: accept at edge N → id_valid high after edge N; one instruction per cycle sustained when ex_ready = 1.
- Reset: id_valid = 0, if_ready = 0 during rst, all id_* outputs = 0, all registers = 0. rst mid-operation discards the slot. if_ready rises in the first cycle after rst falls.
- A load-use bubble lasts exactly as long as ex_load_valid matches; normally one cycle.
- Slot outputs stay stable while id_valid & !ex_ready, except for operand refresh.
- flush together with ex_ready: the slot is dropped and no handoff is counted.

## Structure
- Package riscv_id_pkg:
  - opcode constants;
  - ALU control encodings;
  - immediate-format enum;
  - an imm_gen function.
- Sub-module id_regfile: parametrised by XLEN and NREGS; 2 asynchronous read ports, 1 synchronous write port, synchronous clear.
- Top level holds the decoder, hazard logic, bypass/refresh muxes and the output slot.

## Test plan
- Reset for 3 cycles, then if_valid with ADD x5,x6,x7 (0x007302B3), PC 0x10000000. Required: if_ready = 0 during reset; next cycle id_valid = 1, id_rd = 5, id_rs1 = 6, id_rs2 = 7, id_alu_ctrl = 0000, id_reg_write = 1.
- SUB x5,x6,x7 (0x407302B3) → id_alu_ctrl = 1000. BEQ x1,x2,-4 (0xFE208EE3) → id_imm = 0xFFFFFFFC, id_reg_write = 0.
- Bypass: wb x6 = 0x55 in the same cycle as accepting 0x007302B3 → id_rs1_data = 0x55.
- Refresh: with ex_ready = 0, accept 0x007302B3, then wb x7 = 0xAA → id_rs2_data = 0xAA one cycle later; the slot still holds the instruction.
- Load-use and flush:
  - Slot holds ADD with ex_load_valid = 1, ex_load_rd = 6 → id_valid = 0 and if_ready = 0 for that cycle, then recovery.
  - flush with if_valid → the slot is empty next cycle.
- NREGS = 16: ADDI x20,x0,1 (0x00100A13) → id_illegal = 1, id_reg_write = 0; a wb to x20 leaves all registers unchanged.
